// File: rtl/keypad_pkg.sv
// keypad_pkg: types, constants and the key map shared by the keypad scanner.
//   state_e  : scanner FSM states.
//   KEY_STAR : code of the '*' key (clears the entry).
//   KEY_HASH : code of the '#' key (commits the entry to binary).
//   keymap() : (row index, column index) -> 4-bit key code.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical layout of a standard 4x4 phone-style keypad.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'd13;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_scanner_bcd4_to_bin.sv
// bcd4_to_bin: combinational 4-digit BCD to binary converter.
//   bcd [15:0] : in,  {thousands, hundreds, tens, ones}, each 0..9
//   bin [13:0] : out, 1000*T + 100*H + 10*Tn + O (max 9999 fits in 14 bits)
module bcd4_to_bin (
  input  logic [15:0] bcd,
  output logic [13:0] bin
);

  logic [13:0] thou;
  logic [13:0] hund;
  logic [13:0] tens;
  logic [13:0] ones;

  assign thou = {10'd0, bcd[15:12]};
  assign hund = {10'd0, bcd[11:8]};
  assign tens = {10'd0, bcd[7:4]};
  assign ones = {10'd0, bcd[3:0]};

  // Constant multipliers; for valid BCD the sum never exceeds 14 bits.
  assign bin = (thou * 14'd1000) + (hund * 14'd100) + (tens * 14'd10) + ones;

endmodule

// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: scans a 4x4 matrix keypad, debounces presses and
// releases, decodes key codes and builds a 4-digit BCD entry that is
// converted to binary when '#' is pressed.
//   clk         : in,  system clock
//   rst_n       : in,  asynchronous active-low reset
//   row_in[3:0] : in,  keypad rows, active-low, asynchronous to clk
//   col_out[3:0]: out, one-cold column strobes (bit c low = column c active)
//   key_valid   : out, one-cycle pulse per accepted press
//   key_code    : out, code of the last accepted key
//   digits      : out, current BCD entry, [15:12] thousands .. [3:0] ones
//   entry_valid : out, one-cycle pulse when '#' is accepted
//   num         : out, binary value of digits captured at the last '#'
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES   = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic        entry_valid,
  output logic [13:0] num
);

  localparam int DW  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_DONE   = DBW'(DEBOUNCE_TICKS);

  state_e         state_q, state_d;
  logic [3:0]     row_s1_q, row_s2_q;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [1:0]     col_q, col_d;
  logic [3:0]     pat_q, pat_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic           key_valid_q, key_valid_d;
  logic           entry_valid_q, entry_valid_d;
  logic [3:0]     key_code_q, key_code_d;
  logic [15:0]    digits_q, digits_d;
  logic [13:0]    num_q, num_d;

  logic           tick;
  logic           rows_idle;
  logic [DBW-1:0] deb_inc;
  logic [1:0]     press_row;
  logic [3:0]     press_code;
  logic [13:0]    digits_bin;

  bcd4_to_bin u_bcd4_to_bin (
    .bcd (digits_q),
    .bin (digits_bin)
  );

  assign tick      = (dwell_q == DWELL_LAST);
  assign rows_idle = (row_s2_q == 4'hF);
  assign deb_inc   = deb_q + 1'b1;

  // Lowest-numbered low row wins when several rows are pulled together.
  always_comb begin
    casez (pat_q)
      4'b???0: press_row = 2'd0;
      4'b??01: press_row = 2'd1;
      4'b?011: press_row = 2'd2;
      default: press_row = 2'd3;
    endcase
  end

  assign press_code = keymap(press_row, col_q);

  always_comb begin
    dwell_d       = tick ? '0 : dwell_q + 1'b1;
    state_d       = state_q;
    col_d         = col_q;
    pat_d         = pat_q;
    deb_d         = deb_q;
    key_valid_d   = 1'b0;
    entry_valid_d = 1'b0;
    key_code_d    = key_code_q;
    digits_d      = digits_q;
    num_d         = num_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (rows_idle) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d   = row_s2_q;
            deb_d   = DBW'(1);
            state_d = DEBOUNCE;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (row_s2_q == pat_q) begin
            if (deb_inc >= DEB_DONE) begin
              // The registered outputs and entry update land on the edge
              // that enters PRESS, so key_valid is high for the PRESS cycle.
              state_d     = PRESS;
              key_valid_d = 1'b1;
              key_code_d  = press_code;
              if (press_code <= 4'd9) begin
                digits_d = {digits_q[11:0], press_code};
              end else if (press_code == KEY_STAR) begin
                digits_d = '0;
              end else if (press_code == KEY_HASH) begin
                num_d         = digits_bin;
                entry_valid_d = 1'b1;
              end
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d = SCAN;
          end
        end
      end

      PRESS: begin
        state_d = RELEASE;
        deb_d   = '0;
      end

      RELEASE: begin
        // Column stays on the pressed key so the release is observable.
        if (tick) begin
          if (rows_idle) begin
            if (deb_inc >= DEB_DONE) begin
              deb_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = '0;
          end
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      row_s1_q      <= 4'hF;
      row_s2_q      <= 4'hF;
      dwell_q       <= '0;
      col_q         <= 2'd0;
      pat_q         <= 4'hF;
      deb_q         <= '0;
      key_valid_q   <= 1'b0;
      entry_valid_q <= 1'b0;
      key_code_q    <= 4'd0;
      digits_q      <= 16'd0;
      num_q         <= 14'd0;
    end else begin
      state_q       <= state_d;
      row_s1_q      <= row_in;
      row_s2_q      <= row_s1_q;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      pat_q         <= pat_d;
      deb_q         <= deb_d;
      key_valid_q   <= key_valid_d;
      entry_valid_q <= entry_valid_d;
      key_code_q    <= key_code_d;
      digits_q      <= digits_d;
      num_q         <= num_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col_out[gi] = (col_q != 2'(gi));
  end

  assign key_valid   = key_valid_q;
  assign entry_valid = entry_valid_q;
  assign key_code    = key_code_q;
  assign digits      = digits_q;
  assign num         = num_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
module tb_keypad_entry_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic        entry_valid;
  logic [13:0] num;

  keypad_entry_scanner #(
    .DWELL_CYCLES   (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .digits      (digits),
    .entry_valid (entry_valid),
    .num         (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] digits;
    logic [13:0] num;
    logic        entry;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  int          kv_count;
  logic [15:0] key_down;
  logic [15:0] digits_m;
  logic [13:0] num_m;

  // Keypad model: row r is pulled low while key (r,c) is held and column c is strobed.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] key_of(input int r, input int c);
    logic [3:0] rc;
    rc = {r[1:0], c[1:0]};
    case (rc)
      4'h0: return 4'd1;  4'h1: return 4'd2;  4'h2: return 4'd3;  4'h3: return 4'd10;
      4'h4: return 4'd4;  4'h5: return 4'd5;  4'h6: return 4'd6;  4'h7: return 4'd11;
      4'h8: return 4'd7;  4'h9: return 4'd8;  4'hA: return 4'd9;  4'hB: return 4'd12;
      4'hC: return 4'd14; 4'hD: return 4'd0;  4'hE: return 4'd15; default: return 4'd13;
    endcase
  endfunction

  function automatic logic [13:0] bcd_value(input logic [15:0] d);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(d[i*4 +: 4]);
    return v[13:0];
  endfunction

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    e.entry = 1'b0;
    if (code <= 4'd9) digits_m = {digits_m[11:0], code};
    else if (code == 4'd14) digits_m = 16'd0;
    else if (code == 4'd15) begin
      num_m   = bcd_value(digits_m);
      e.entry = 1'b1;
    end
    e.code   = code;
    e.digits = digits_m;
    e.num    = num_m;
    exp_q.push_back(e);
  endtask

  // Press key (r,c), wait for its pulse, hold, release, then let the release settle.
  task automatic press_key(input int r, input int c, input int hold, input int settle);
    int start;
    push_expect(key_of(r, c));
    start = kv_count;
    key_down[r*4+c] = 1'b1;
    for (int i = 0; i < 300 && kv_count == start; i++) @(negedge clk);
    expect_eq("press_pulse", kv_count - start, 1);
    repeat (hold) @(negedge clk);
    key_down[r*4+c] = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  // Scoreboard consumer: every key_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (key_valid) begin
      kv_count++;
      if (exp_q.size() == 0) expect_eq("unexpected_key_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        expect_eq("key_code", key_code, e.code);
        expect_eq("digits", digits, e.digits);
        expect_eq("num", num, e.num);
        expect_eq("entry_valid", entry_valid, e.entry);
        $display("key %0d digits %04h num %0d entry %0b", key_code, digits, num, entry_valid);
      end
    end else if (entry_valid) begin
      expect_eq("stray_entry_valid", 1, 0);
    end
  end

  initial begin
    int          n;
    int          k0;
    logic [3:0]  one;
    logic [3:0]  col_exp;
    vectors     = 0;
    miscompares = 0;
    kv_count    = 0;
    key_down    = 16'd0;
    digits_m    = 16'd0;
    num_m       = 14'd0;
    one         = 4'b0001;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_col_out", col_out, 4'b1110);
    expect_eq("rst_key_valid", key_valid, 0);
    expect_eq("rst_entry_valid", entry_valid, 0);
    expect_eq("rst_key_code", key_code, 0);
    expect_eq("rst_digits", digits, 0);
    expect_eq("rst_num", num, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Long hold of key 5: one pulse, then scanning resumes at column 2.
    k0 = kv_count;
    press_key(1, 1, 160, 0);
    n = 0;
    while (col_out == 4'b1101 && n < 60) begin
      @(negedge clk);
      n++;
    end
    expect_eq("resume_col2", col_out, 4'b1011);
    expect_eq("key5_single", kv_count - k0, 1);
    for (int k = 0; k < 4; k++) begin
      col_exp = ~(one << ((2 + k) % 4));
      repeat (3) @(negedge clk);
      expect_eq("col_dwell", col_out, col_exp);
      @(negedge clk);
      col_exp = ~(one << ((3 + k) % 4));
      expect_eq("col_step", col_out, col_exp);
    end

    // Entry 1234 #, 9999 #, then 5.
    press_key(0, 0, 6, 24);
    press_key(0, 1, 6, 24);
    press_key(0, 2, 6, 24);
    press_key(1, 0, 6, 24);
    press_key(3, 2, 6, 24);
    expect_eq("num_1234", num, 14'd1234);
    for (int i = 0; i < 4; i++) press_key(2, 2, 6, 24);
    press_key(3, 2, 6, 24);
    expect_eq("num_9999", num, 14'd9999);
    press_key(1, 1, 6, 24);
    expect_eq("digits_9995", digits, 16'h9995);

    // Bounce on key 1: low 2 ticks, high 1 tick, low 2 ticks, aligned to column 0.
    n = 0;
    while (col_out != 4'b0111 && n < 40) begin @(negedge clk); n++; end
    while (col_out != 4'b1110 && n < 80) begin @(negedge clk); n++; end
    k0 = kv_count;
    key_down[0] = 1'b1;
    repeat (8) @(negedge clk);
    key_down[0] = 1'b0;
    repeat (4) @(negedge clk);
    key_down[0] = 1'b1;
    repeat (8) @(negedge clk);
    key_down[0] = 1'b0;
    repeat (24) @(negedge clk);
    expect_eq("bounce_no_key", kv_count - k0, 0);

    // Rows 1 and 2 together on column 0: row 1 (key 4) wins.
    push_expect(4'd4);
    k0 = kv_count;
    key_down[4] = 1'b1;
    key_down[8] = 1'b1;
    for (int i = 0; i < 300 && kv_count == k0; i++) @(negedge clk);
    expect_eq("multirow_pulse", kv_count - k0, 1);
    key_down[4] = 1'b0;
    key_down[8] = 1'b0;
    repeat (24) @(negedge clk);

    // Clear with *, then A leaves the entry alone.
    press_key(3, 0, 6, 24);
    press_key(0, 3, 6, 24);
    expect_eq("digits_clear", digits, 16'h0000);
    expect_eq("num_kept", num, 14'd9999);

    // Reset while key 7 is held in RELEASE: one fresh press after reset.
    press_key(2, 0, 0, 0);
    key_down[8] = 1'b1;
    repeat (6) @(negedge clk);
    k0 = kv_count;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("midrst_col_out", col_out, 4'b1110);
    expect_eq("midrst_digits", digits, 0);
    expect_eq("midrst_num", num, 0);
    expect_eq("midrst_key_code", key_code, 0);
    expect_eq("midrst_key_valid", key_valid, 0);
    digits_m = 16'd0;
    num_m    = 14'd0;
    repeat (10) @(negedge clk);
    expect_eq("no_pulse_in_reset", kv_count - k0, 0);
    push_expect(4'd7);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && kv_count == k0; i++) @(negedge clk);
    expect_eq("held_after_reset", kv_count - k0, 1);
    repeat (40) @(negedge clk);
    expect_eq("held_no_repeat", kv_count - k0, 1);
    key_down[8] = 1'b0;
    repeat (24) @(negedge clk);
    expect_eq("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
